step_run_controller: RTL
========================

// Module: step_run_controller
// PURPOSE
//  Sequences the CPU datapath clock-enable from the front-panel controls: free run,
//  single cycle, single instruction, breakpoint stop and HLT stop.
//  Sits between the board buttons/switches and the datapath clock gate.
//  Runs on the design oscillator clock.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  cycles i_btnStep must stay stable before a press/release is accepted
//  ADDR_WIDTH       16     width of i_pc / i_breakpointAddress
// PORTS
//  i_oszClk              in   1   design clock; all logic on posedge
//  i_resetn              in   1   asynchronous, active-low reset
//  i_btnStep             in   1   raw step button, 1 = pressed
//  i_swInstrNCycle       in   1   1 = step one instruction, 0 = step one cycle
//  i_swStepNRun          in   1   1 = step mode, 0 = run mode
//  i_swEnableBreakpoint  in   1   1 = breakpoint compare active
//  i_breakpointAddress   in   16  breakpoint PC
//  i_pc                  in   16  datapath program counter
//  i_instrStart          in   1   datapath is in first micro-cycle of an instruction
//  i_halt                in   1   datapath executing HLT
//  o_clkEnable           out  1   datapath advances on next i_oszClk edge when 1
//  o_state               out  3   HALT=0 RUN=1 STEP_CYCLE=2 STEP_INSTR=3 BREAK=4
//  o_breakpointHit       out  1   1 while in BREAK
// BEHAVIOUR
//  - Reset: state=HALT, o_clkEnable=0, o_breakpointHit=0, r_haltLatched=0, r_guard=0,
//    synchronisers and debounce counter cleared. Reset mid-step aborts immediately.
//  - Switches and button pass 2-flop synchronisers. Button debounce: counter restarts on
//    every change of the synced level. Level is accepted after DEBOUNCE_CYCLES stable cycles.
//    "press" = one-cycle pulse on the debounced 0->1 edge.
//  - o_clkEnable is combinational from state and stop terms. It drops in the same cycle as a
//    stop condition, so the stopping edge is never taken.
//  - HALT: en=0.
//    -> RUN if swStepNRun=0 and !r_haltLatched.
//    On press: run mode -> RUN and clear r_haltLatched; step mode -> STEP_INSTR if
//    swInstrNCycle else STEP_CYCLE.
//  - STEP_CYCLE: en=1 for exactly one cycle, then HALT.
//  - STEP_INSTR: en=1. r_started is set after the first enabled cycle.
//    -> HALT with en=0 in the cycle where (i_instrStart & r_started) or i_halt.
//    i_halt also sets r_haltLatched.
//  - RUN: en=1 unless a stop term applies; all stop terms give en=0 in the same cycle.
//    swStepNRun=1 -> HALT.
//    i_halt -> HALT and set r_haltLatched.
//    Breakpoint match (i_swEnableBreakpoint & i_instrStart & i_pc==i_breakpointAddress
//    & !r_guard) -> BREAK.
//    r_guard clears after the first enabled cycle of RUN.
//  - BREAK: en=0, o_breakpointHit=1.
//    swStepNRun=1 -> HALT.
//    Press in run mode -> RUN with r_guard=1, so the same PC does not retrigger.
//  - Priority within a cycle: i_resetn > i_halt > breakpoint > mode switch > press.
//  - Press held across states counts once. A press while not in HALT/BREAK is ignored.
//  - Switch changes during STEP_CYCLE/STEP_INSTR do not abort the step.
//  - Breakpoint compare is full ADDR_WIDTH equality. Breakpoint disabled => BREAK is never
//    entered.
// TESTING
//  - Reset with swStepNRun=1 -> state=0, en=0; one press (swInstrNCycle=0) -> en high for
//    exactly 1 cycle, state back to 0.
//  - swInstrNCycle=1, instrStart pulses every 4 cycles, press -> en high for exactly 4
//    cycles, drops in cycle of next instrStart.
//  - Run mode, bp=16'h0010, bp enabled, pc reaches 0x0010 with instrStart -> en=0 that cycle,
//    state=4, hit=1. Press -> RUN, no retrigger at 0x0010, next match traps again.
//  - Button bounce 0/1 every 10 cycles for 500 cycles then stable 1 (DEBOUNCE_CYCLES=100)
//    -> exactly one step executed.
//  - RUN, i_halt=1 -> en=0 same cycle, state=0, stays HALT with switch in run until press.
//  - Assert i_resetn=0 mid STEP_INSTR -> en=0 asynchronously, state=0 on release.

Source files
------------

// File: rtl/step_run_controller.sv
// Front-panel sequencer that gates the datapath clock: free run, single cycle, single instruction, breakpoint and HLT stops.
// Latency: switches and button pass 2-flop synchronisers, and the button also needs DEBOUNCE_CYCLES stable cycles; stop conditions drop o_clkEnable in the same cycle.
// Backpressure: none; o_clkEnable is the only throttle, and a press that arrives outside HALT/BREAK is ignored.
module step_run_controller #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int ADDR_WIDTH      = 16
) (
   input  logic                  i_oszClk,
   input  logic                  i_resetn,
   input  logic                  i_btnStep,
   input  logic                  i_swInstrNCycle,
   input  logic                  i_swStepNRun,
   input  logic                  i_swEnableBreakpoint,
   input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   input  logic                  i_instrStart,
   input  logic                  i_halt,
   output logic                  o_clkEnable,
   output logic [2:0]            o_state,
   output logic                  o_breakpointHit
);

   localparam logic [2:0] ST_HALT       = 3'd0;
   localparam logic [2:0] ST_RUN        = 3'd1;
   localparam logic [2:0] ST_STEP_CYCLE = 3'd2;
   localparam logic [2:0] ST_STEP_INSTR = 3'd3;
   localparam logic [2:0] ST_BREAK      = 3'd4;

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Synchroniser stages; bit 1 is the synchronised value.
   // The mode switch is carried as "run mode" so that the cleared reset value
   // means step mode and the datapath never free-runs before the switch is seen.
   logic [1:0]       r_btnSync;
   logic [1:0]       r_instrSync;
   logic [1:0]       r_runSync;
   logic [1:0]       r_bpEnSync;

   logic [CNT_W-1:0] r_debCnt;
   logic             r_btnDeb;
   logic             r_btnDebD;

   logic [2:0]       r_state;
   logic             r_haltLatched;
   logic             r_guard;
   logic             r_started;

   logic             stepMode;
   logic             instrMode;
   logic             press;
   logic             bpMatch;
   logic             instrDone;
   logic             runStop;
   logic             clkEnable;

   // Two-flop synchronisers for the asynchronous front-panel inputs.
   always_ff @(posedge i_oszClk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_btnSync   <= '0;
         r_instrSync <= '0;
         r_runSync   <= '0;
         r_bpEnSync  <= '0;
      end else begin
         r_btnSync   <= {r_btnSync[0],   i_btnStep};
         r_instrSync <= {r_instrSync[0], i_swInstrNCycle};
         r_runSync   <= {r_runSync[0],   ~i_swStepNRun};
         r_bpEnSync  <= {r_bpEnSync[0],  i_swEnableBreakpoint};
      end
   end

   // Button debounce: any return to the accepted level restarts the count.
   always_ff @(posedge i_oszClk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_debCnt  <= '0;
         r_btnDeb  <= 1'b0;
         r_btnDebD <= 1'b0;
      end else begin
         r_btnDebD <= r_btnDeb;
         if (r_btnSync[1] == r_btnDeb) begin
            r_debCnt <= '0;
         end else if (r_debCnt == DEB_LAST) begin
            r_btnDeb <= r_btnSync[1];
            r_debCnt <= '0;
         end else begin
            r_debCnt <= r_debCnt + CNT_ONE;
         end
      end
   end

   assign stepMode  = ~r_runSync[1];
   assign instrMode = r_instrSync[1];
   assign press     = r_btnDeb & ~r_btnDebD;

   // Stop terms and clock enable; stops act in the same cycle so the stopping edge is never taken.
   always_comb begin
      bpMatch   = r_bpEnSync[1] & i_instrStart & (i_pc == i_breakpointAddress) & ~r_guard;
      instrDone = (i_instrStart & r_started) | i_halt;
      runStop   = i_halt | bpMatch | stepMode;
      clkEnable = 1'b0;
      case (r_state)
         ST_RUN:        clkEnable = ~runStop;
         ST_STEP_CYCLE: clkEnable = 1'b1;
         ST_STEP_INSTR: clkEnable = ~instrDone;
         default:       clkEnable = 1'b0;
      endcase
   end

   // Run/step state machine; i_halt outranks the breakpoint, which outranks the mode switch and the button.
   always_ff @(posedge i_oszClk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state       <= ST_HALT;
         r_haltLatched <= 1'b0;
         r_guard       <= 1'b0;
         r_started     <= 1'b0;
      end else begin
         case (r_state)
            ST_HALT: begin
               if (press) begin
                  if (stepMode) begin
                     r_state   <= instrMode ? ST_STEP_INSTR : ST_STEP_CYCLE;
                     r_started <= 1'b0;
                  end else begin
                     r_state       <= ST_RUN;
                     r_haltLatched <= 1'b0;
                  end
               end else if (!stepMode && !r_haltLatched) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // The resume guard only has to cover the instruction we stopped on.
               if (clkEnable) r_guard <= 1'b0;
               if (i_halt) begin
                  r_state       <= ST_HALT;
                  r_haltLatched <= 1'b1;
               end else if (bpMatch) begin
                  r_state <= ST_BREAK;
               end else if (stepMode) begin
                  r_state <= ST_HALT;
               end
            end
            ST_STEP_CYCLE: begin
               r_state <= ST_HALT;
            end
            ST_STEP_INSTR: begin
               // The first cycle may itself be an instruction start; only later ones end the step.
               if (clkEnable) r_started <= 1'b1;
               if (instrDone) begin
                  r_state <= ST_HALT;
                  if (i_halt) r_haltLatched <= 1'b1;
               end
            end
            ST_BREAK: begin
               if (stepMode) begin
                  r_state <= ST_HALT;
               end else if (press) begin
                  r_state <= ST_RUN;
                  r_guard <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_HALT;
            end
         endcase
      end
   end

   assign o_clkEnable     = clkEnable;
   assign o_state         = r_state;
   assign o_breakpointHit = (r_state == ST_BREAK);

endmodule
